sram_word_ctrl: RTL and testbench

SRAM_WORD_CTRL -- requirements
Module: sram_word_ctrl

---
 rtl/sram_ctrl_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 35 +++
 rtl/sram_word_ctrl.sv | 136 +++++++++++++
 tb/tb_sram_word_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the word-to-byte SRAM controller: FSM states,
// default SRAM depth and the one-hot byte-lane masks.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_B0,
        WR_B1,
        WR_B2,
        WR_B3,
        RD_ISSUE,
        RD_RSP,
        ERR
    } state_e;

    localparam int DEPTH_DEFAULT = 256;

    localparam logic [3:0] BM_B0 = 4'b0001;
    localparam logic [3:0] BM_B1 = 4'b0010;
    localparam logic [3:0] BM_B2 = 4'b0100;
    localparam logic [3:0] BM_B3 = 4'b1000;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; grants are combinational from requests.
// The loser of the last grant gets priority next; requester A wins first after reset.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    logic prio_b_q;
    logic prio_b_d;

    always_comb begin
        gnt_a_o  = en_i && req_a_i && (!req_b_i || !prio_b_q);
        gnt_b_o  = en_i && req_b_i && (!req_a_i || prio_b_q);
        prio_b_d = prio_b_q;
        if (gnt_a_o) begin
            prio_b_d = 1'b1;
        end else if (gnt_b_o) begin
            prio_b_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end

endmodule

// File: rtl/sram_word_ctrl.sv
// 32-bit word access to a byte-masked SRAM: writes take 5 cycles (accept + 4 bytes),
// reads return 2 cycles after accept; new requests are only accepted while idle.
module sram_word_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_rsp_valid,
    output logic [31:0]       rd_rsp_data,
    output logic              addr_err,
    output logic              busy,
    output logic              sram_csb,
    output logic              sram_wsb,
    output logic [3:0]        sram_bytemask,
    output logic [7:0]        sram_wdata,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [31:0]       sram_rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic                err_q, err_d;
    logic                wr_oor, rd_oor;
    logic                arb_en;

    assign wr_oor = {1'b0, wr_addr} >= DEPTH_L;
    assign rd_oor = {1'b0, rd_addr} >= DEPTH_L;
    // Gating with rst_n keeps both readies low while reset is held.
    assign arb_en = (state_q == IDLE) && rst_n;
    assign busy   = (state_q != IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (arb_en),
        .req_a_i (wr_valid),
        .req_b_i (rd_valid),
        .gnt_a_o (wr_ready),
        .gnt_b_o (rd_ready)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (wr_ready) begin
                    addr_d  = wr_addr;
                    data_d  = wr_data;
                    err_d   = wr_oor;
                    state_d = wr_oor ? ERR : WR_B0;
                end else if (rd_ready) begin
                    addr_d  = rd_addr;
                    err_d   = rd_oor;
                    state_d = rd_oor ? RD_RSP : RD_ISSUE;
                end
            end
            WR_B0:    state_d = WR_B1;
            WR_B1:    state_d = WR_B2;
            WR_B2:    state_d = WR_B3;
            WR_B3:    state_d = IDLE;
            RD_ISSUE: state_d = RD_RSP;
            RD_RSP:   state_d = IDLE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Each write state drives a fixed one-hot mask: any other mask would wipe the word.
    always_comb begin
        sram_csb      = 1'b1;
        sram_wsb      = 1'b1;
        sram_bytemask = 4'b0000;
        sram_wdata    = 8'h00;
        sram_waddr    = '0;
        sram_raddr    = '0;
        rd_rsp_valid  = 1'b0;
        rd_rsp_data   = 32'h0;
        addr_err      = 1'b0;
        case (state_q)
            WR_B0, WR_B1, WR_B2, WR_B3: begin
                sram_csb   = 1'b0;
                sram_wsb   = 1'b0;
                sram_waddr = addr_q;
                case (state_q)
                    WR_B0: begin sram_bytemask = BM_B0; sram_wdata = data_q[7:0];   end
                    WR_B1: begin sram_bytemask = BM_B1; sram_wdata = data_q[15:8];  end
                    WR_B2: begin sram_bytemask = BM_B2; sram_wdata = data_q[23:16]; end
                    default: begin sram_bytemask = BM_B3; sram_wdata = data_q[31:24]; end
                endcase
            end
            RD_ISSUE: begin
                sram_csb   = 1'b0;
                sram_raddr = addr_q;
            end
            RD_RSP: begin
                rd_rsp_valid = 1'b1;
                rd_rsp_data  = err_q ? 32'h0 : sram_rdata;
                addr_err     = err_q;
            end
            ERR: addr_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Bench for sram_word_ctrl: byte-masked SRAM model, directed vector table,
// hand-written arbitration/reset sequences and random traffic against a word-array model.
module tb_sram_word_ctrl;

    localparam int AW    = 10;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [31:0]   wr_data;
    logic          rd_rsp_valid;
    logic [31:0]   rd_rsp_data;
    logic          addr_err, busy;
    logic          sram_csb, sram_wsb;
    logic [3:0]    sram_bytemask;
    logic [7:0]    sram_wdata;
    logic [AW-1:0] sram_waddr, sram_raddr;
    logic [31:0]   sram_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem     [0:(1<<AW)-1] = '{default: 32'h0};
    logic [31:0] ref_mem [0:DEPTH-1]   = '{default: 32'h0};

    always #5 clk = ~clk;

    sram_word_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rd_rsp_valid  (rd_rsp_valid),
        .rd_rsp_data   (rd_rsp_data),
        .addr_err      (addr_err),
        .busy          (busy),
        .sram_csb      (sram_csb),
        .sram_wsb      (sram_wsb),
        .sram_bytemask (sram_bytemask),
        .sram_wdata    (sram_wdata),
        .sram_waddr    (sram_waddr),
        .sram_raddr    (sram_raddr),
        .sram_rdata    (sram_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SRAM model: a non-one-hot mask during a write clears the whole word.
    always @(posedge clk) begin
        if (!sram_csb && !sram_wsb) begin
            chk("sram_mask_onehot", 64'($countones(sram_bytemask)), 64'd1);
            if ($countones(sram_bytemask) == 1) begin
                for (int b = 0; b < 4; b++)
                    if (sram_bytemask[b]) mem[sram_waddr][8*b +: 8] <= sram_wdata;
            end else begin
                mem[sram_waddr] <= 32'h0;
            end
        end
        if (!sram_csb && sram_wsb) sram_rdata <= mem[sram_raddr];
    end

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [31:0]   exp_rd;
        bit            exp_err;
    } vec_t;

    vec_t vecs [10];

    // Issues one request starting at a negedge and checks every cycle until idle.
    task automatic do_op(input bit is_wr, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input bit exp_err);
        bit acc = 0;
        if (is_wr) begin wr_valid = 1; wr_addr = a; wr_data = d; end
        else begin rd_valid = 1; rd_addr = a; end
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            if (is_wr ? wr_ready : rd_ready) acc = 1;
            @(negedge clk);
        end
        if (!acc) begin
            chk("handshake_timeout", 64'd0, 64'd1);
            wr_valid = 0; rd_valid = 0;
            return;
        end
        if (is_wr && !exp_err) begin
            for (int k = 0; k < 4; k++) begin
                if (k > 0) @(negedge clk);
                chk("wr_csb", sram_csb, 0);
                chk("wr_wsb", sram_wsb, 0);
                chk("wr_mask", sram_bytemask, 64'd1 << k);
                chk("wr_byte", sram_wdata, d[8*k +: 8]);
                chk("wr_waddr", sram_waddr, a);
                if (k == 0) wr_valid = 0;
            end
            @(negedge clk);
            chk("wr_done_busy", busy, 0);
            chk("wr_done_csb", sram_csb, 1);
        end else if (is_wr) begin
            chk("wr_err_pulse", addr_err, 1);
            chk("wr_err_wsb", sram_wsb, 1);
            chk("wr_err_csb", sram_csb, 1);
            chk("wr_err_busy", busy, 1);
            wr_valid = 0;
            @(negedge clk);
            chk("wr_err_end", addr_err, 0);
            chk("wr_err_idle", busy, 0);
        end else if (!exp_err) begin
            chk("rd_issue_csb", sram_csb, 0);
            chk("rd_issue_wsb", sram_wsb, 1);
            chk("rd_issue_raddr", sram_raddr, a);
            chk("rd_issue_norsp", rd_rsp_valid, 0);
            rd_valid = 0;
            @(negedge clk);
            chk("rd_rsp_valid", rd_rsp_valid, 1);
            chk("rd_rsp_data", rd_rsp_data, exp_rd);
            chk("rd_rsp_err", addr_err, 0);
            chk("rd_rsp_csb", sram_csb, 1);
            @(negedge clk);
            chk("rd_rsp_single", rd_rsp_valid, 0);
            chk("rd_idle", busy, 0);
        end else begin
            chk("rd_err_valid", rd_rsp_valid, 1);
            chk("rd_err_data", rd_rsp_data, 0);
            chk("rd_err_pulse", addr_err, 1);
            chk("rd_err_csb", sram_csb, 1);
            rd_valid = 0;
            @(negedge clk);
            chk("rd_err_single", rd_rsp_valid, 0);
            chk("rd_err_end", addr_err, 0);
            chk("rd_err_idle", busy, 0);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] wexp;
        logic [31:0] old7;
        int          grants;
        bit          gw, gr;
        bit          exp_w;

        vecs[0] = '{1'b1, 10'd5,   32'hA1B2C3D4, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 10'd5,   32'h0,        32'hA1B2C3D4, 1'b0};
        vecs[2] = '{1'b1, 10'd256, 32'h55AA55AA, 32'h0,        1'b1};
        vecs[3] = '{1'b1, 10'd255, 32'h01020304, 32'h0,        1'b0};
        vecs[4] = '{1'b0, 10'd255, 32'h0,        32'h01020304, 1'b0};
        vecs[5] = '{1'b0, 10'd300, 32'h0,        32'h0,        1'b1};
        vecs[6] = '{1'b0, 10'd256, 32'h0,        32'h0,        1'b1};
        vecs[7] = '{1'b1, 10'd0,   32'hDEADBEEF, 32'h0,        1'b0};
        vecs[8] = '{1'b0, 10'd0,   32'h0,        32'hDEADBEEF, 1'b0};
        vecs[9] = '{1'b0, 10'd5,   32'h0,        32'hA1B2C3D4, 1'b0};

        // Reset state, with requests already asserted.
        rst_n = 0; wr_valid = 1; rd_valid = 1;
        wr_addr = '0; rd_addr = '0; wr_data = 32'h0;
        #12;
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_csb", sram_csb, 1);
        chk("rst_wsb", sram_wsb, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rd_rsp_valid, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_bytemask", sram_bytemask, 0);
        wr_valid = 0; rd_valid = 0;
        @(negedge clk);
        rst_n = 1;

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].is_wr, vecs[i].addr, vecs[i].data, vecs[i].exp_rd, vecs[i].exp_err);
            if (vecs[i].is_wr && !vecs[i].exp_err) ref_mem[vecs[i].addr] = vecs[i].data;
        end

        // Round-robin with both requests held: expect W,R,W,R after reset.
        apply_reset();
        wr_valid = 1; wr_addr = 10'd20; wr_data = 32'h13579BDF;
        rd_valid = 1; rd_addr = 10'd21;
        grants = 0;
        exp_w  = 1;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            #1;
            gw = wr_ready; gr = rd_ready;
            if (gw || gr) begin
                chk("arb_grant_is_wr", gw, exp_w);
                chk("arb_single_grant", gw && gr, 0);
                exp_w = !exp_w;
                grants++;
            end
            @(negedge clk);
        end
        chk("arb_grant_count", grants, 4);
        wr_valid = 0; rd_valid = 0;
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        chk("arb_idle", busy, 0);
        ref_mem[20] = 32'h13579BDF;

        // Reset dropped during WR_B2: bytes 0-1 land, bytes 2-3 keep old value.
        do_op(1, 10'd7, 32'hCAFEF00D, 32'h0, 0);
        ref_mem[7] = 32'hCAFEF00D;
        old7 = ref_mem[7];
        wr_valid = 1; wr_addr = 10'd7; wr_data = 32'h11223344;
        #1;
        chk("rstmid_accept", wr_ready, 1);
        @(negedge clk);
        wr_valid = 0;
        repeat (2) @(negedge clk);
        chk("rstmid_in_b2", sram_bytemask, 4'b0100);
        rst_n = 0;
        #1;
        chk("rstmid_csb", sram_csb, 1);
        chk("rstmid_wsb", sram_wsb, 1);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_mask", sram_bytemask, 0);
        chk("rstmid_wdata", sram_wdata, 0);
        chk("rstmid_rsp", rd_rsp_valid, 0);
        wexp = {old7[31:16], 16'h3344};
        @(negedge clk);
        chk("rstmid_sram_word", mem[7], wexp);
        rst_n = 1;
        ref_mem[7] = wexp;
        do_op(0, 10'd7, 32'h0, wexp, 0);

        // Random traffic against the word-array model.
        for (int n = 0; n < 60; n++) begin
            bit            w;
            int            sel;
            logic [AW-1:0] a;
            logic [31:0]   d;
            bit            oor;
            w   = bit'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = AW'($urandom_range(DEPTH, (1 << AW) - 1));
            else if (sel < 4)  a = AW'($urandom_range(0, DEPTH - 1));
            else               a = AW'($urandom_range(0, 15));
            d   = $urandom;
            oor = (int'(a) >= DEPTH);
            do_op(w, a, d, oor ? 32'h0 : ref_mem[a[7:0]], oor);
            if (w && !oor) ref_mem[a[7:0]] = d;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
